// File: rtl/busca_instrucao.sv
// Instruction fetch stage: holds PC and IR, fetches one word per instruction
// over a req/ack handshake and selects the next PC (jump target or PC+1).
module busca_instrucao #(
  parameter int unsigned       ADDR_W   = 12,
  parameter int unsigned       DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_data,
  output logic [3:0]        opcode,
  output logic [ADDR_W-1:0] operand,
  output logic              instr_valid,
  input  logic              exec_done,
  input  logic              pc_src,
  input  logic              jmp_uncond,
  output logic [ADDR_W-1:0] pc
);

  localparam int unsigned OP_W = 4;

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [OP_W-1:0]   ir_op;
  logic [OP_W-1:0]   ir_op_next;
  logic [ADDR_W-1:0] ir_operand;
  logic [ADDR_W-1:0] ir_operand_next;
  logic [ADDR_W-1:0] pc_next;
  logic              take_jump;

  // State, PC and IR registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir_op      <= '0;
      ir_operand <= '0;
    end else begin
      state      <= state_next;
      pc         <= pc_next;
      ir_op      <= ir_op_next;
      ir_operand <= ir_operand_next;
    end
  end

  assign take_jump = pc_src | jmp_uncond;

  // Next-state, IR load and PC selection
  always_comb begin
    state_next      = state;
    pc_next         = pc;
    ir_op_next      = ir_op;
    ir_operand_next = ir_operand;
    case (state)
      S_FETCH: begin
        if (imem_ack) begin
          ir_op_next      = imem_data[DATA_W-1 -: OP_W];
          ir_operand_next = imem_data[ADDR_W-1:0];
          state_next      = S_EXEC;
        end
      end
      S_EXEC: begin
        if (exec_done) begin
          // PC+1 wraps naturally at ADDR_W bits
          pc_next    = take_jump ? ir_operand : pc + ADDR_W'(1);
          state_next = S_FETCH;
        end
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Moore outputs; request is held low for as long as reset is asserted
  assign imem_req    = (state == S_FETCH) && !rst;
  assign imem_addr   = pc;
  assign instr_valid = (state == S_EXEC);
  assign opcode      = ir_op;
  assign operand     = ir_operand;

endmodule

// File: tb/tb_busca_instrucao.sv
// Directed self-checking bench for busca_instrucao (RESET_PC = 0x010).
module tb_busca_instrucao;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ack;
  logic [DATA_W-1:0] imem_data;
  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic              instr_valid;
  logic              exec_done;
  logic              pc_src;
  logic              jmp_uncond;
  logic [ADDR_W-1:0] pc;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int cyc_mark;

  busca_instrucao #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(12'h010)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_data  (imem_data),
    .opcode     (opcode),
    .operand    (operand),
    .instr_valid(instr_valid),
    .exec_done  (exec_done),
    .pc_src     (pc_src),
    .jmp_uncond (jmp_uncond),
    .pc         (pc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [DATA_W-1:0] word);
    imem_ack  = 1'b1;
    imem_data = word;
    step();
    imem_ack  = 1'b0;
    imem_data = '0;
  endtask

  task automatic complete(input logic src, input logic jmp);
    exec_done  = 1'b1;
    pc_src     = src;
    jmp_uncond = jmp;
    step();
    exec_done  = 1'b0;
    pc_src     = 1'b0;
    jmp_uncond = 1'b0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_data = '0;
    exec_done = 1'b0; pc_src = 1'b0; jmp_uncond = 1'b0;
    #3;
    chk("rst_req", 32'(imem_req), 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'h0);
    chk("rst_opcode", 32'(opcode), 32'h0);
    chk("rst_operand", 32'(operand), 32'h0);
    chk("rst_pc", 32'(pc), 32'h010);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_req", 32'(imem_req), 32'h1);
    chk("rel_addr", 32'(imem_addr), 32'h010);
    chk("rel_valid", 32'(instr_valid), 32'h0);

    // Jump variants
    fetch(16'h8ABC);
    chk("j1_valid", 32'(instr_valid), 32'h1);
    chk("j1_req", 32'(imem_req), 32'h0);
    chk("j1_opcode", 32'(opcode), 32'h8);
    chk("j1_operand", 32'(operand), 32'hABC);
    complete(1'b0, 1'b1);
    chk("j1_addr", 32'(imem_addr), 32'hABC);
    chk("j1_req_back", 32'(imem_req), 32'h1);
    fetch(16'h8ABC);
    complete(1'b1, 1'b0);
    chk("j2_addr", 32'(imem_addr), 32'hABC);
    fetch(16'h8ABC);
    complete(1'b0, 1'b0);
    chk("j3_addr", 32'(imem_addr), 32'hABD);
    fetch(16'h8000);
    complete(1'b1, 1'b1);
    chk("j4_addr", 32'(pc), 32'h000);

    // Sequential, zero wait states
    cyc_mark = cyc;
    fetch(16'h2005);
    chk("s1_opcode", 32'(opcode), 32'h2);
    chk("s1_operand", 32'(operand), 32'h005);
    complete(1'b0, 1'b0);
    chk("s1_addr", 32'(imem_addr), 32'h001);
    fetch(16'h3006);
    chk("s2_opcode", 32'(opcode), 32'h3);
    chk("s2_operand", 32'(operand), 32'h006);
    complete(1'b0, 1'b0);
    chk("s2_addr", 32'(imem_addr), 32'h002);
    chk("s_cycles", 32'(cyc - cyc_mark), 32'd4);

    // Wait states with stray handshakes
    exec_done = 1'b1; jmp_uncond = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("w_fetch_addr", 32'(imem_addr), 32'h002);
      chk("w_fetch_req", 32'(imem_req), 32'h1);
      chk("w_fetch_valid", 32'(instr_valid), 32'h0);
    end
    exec_done = 1'b0; jmp_uncond = 1'b0;
    fetch(16'h5123);
    imem_ack = 1'b1; imem_data = 16'hFFFF;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("w_exec_opcode", 32'(opcode), 32'h5);
      chk("w_exec_operand", 32'(operand), 32'h123);
      chk("w_exec_pc", 32'(pc), 32'h002);
      chk("w_exec_valid", 32'(instr_valid), 32'h1);
    end
    imem_ack = 1'b0; imem_data = '0;
    complete(1'b0, 1'b0);
    chk("w_addr", 32'(imem_addr), 32'h003);

    // Wrap from all-ones, opcode 0000 handled like any other
    fetch(16'h9FFF);
    complete(1'b0, 1'b1);
    chk("wrap_pre", 32'(pc), 32'hFFF);
    fetch(16'h0000);
    chk("op0_valid", 32'(instr_valid), 32'h1);
    chk("op0_opcode", 32'(opcode), 32'h0);
    complete(1'b0, 1'b0);
    chk("wrap_addr", 32'(imem_addr), 32'h000);

    // Asynchronous reset mid-cycle while executing
    fetch(16'h1234);
    #2 rst = 1'b1;
    #1;
    chk("ar_req", 32'(imem_req), 32'h0);
    chk("ar_valid", 32'(instr_valid), 32'h0);
    chk("ar_opcode", 32'(opcode), 32'h0);
    chk("ar_operand", 32'(operand), 32'h0);
    chk("ar_pc", 32'(pc), 32'h010);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ar_rel_req", 32'(imem_req), 32'h1);
    chk("ar_rel_addr", 32'(imem_addr), 32'h010);

    // Reset during pending fetch, with an ack in the reset cycle
    @(negedge clk);
    complete(1'b0, 1'b0);
    chk("rf_pc_still", 32'(pc), 32'h010);
    rst = 1'b1; imem_ack = 1'b1; imem_data = 16'h7123;
    step();
    chk("rf_valid", 32'(instr_valid), 32'h0);
    chk("rf_opcode", 32'(opcode), 32'h0);
    rst = 1'b0; imem_ack = 1'b0; imem_data = '0;
    #1;
    chk("rf_req", 32'(imem_req), 32'h1);
    chk("rf_addr", 32'(imem_addr), 32'h010);
    @(negedge clk);
    step();
    chk("rf_c1_valid", 32'(instr_valid), 32'h0);
    fetch(16'h4555);
    chk("rf_valid2", 32'(instr_valid), 32'h1);
    chk("rf_opcode2", 32'(opcode), 32'h4);
    chk("rf_operand2", 32'(operand), 32'h555);
    complete(1'b0, 1'b0);
    chk("rf_next", 32'(imem_addr), 32'h011);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/busca_instrucao.md
# busca_instrucao

Instruction fetch stage of the accumulator CPU: holds the program counter and the instruction register, and fetches one instruction word per instruction from instruction memory over a request/acknowledge handshake. It splits the word into a 4-bit opcode for the control unit and an address operand for the datapath. It then holds them stable until execution completes. Using the control unit's `pc_src`/`jmp_uncond` flags, it selects the next PC: the operand (jump) or PC+1.

## Interface
- `ADDR_W`, 12, width of PC, memory address and operand
- `DATA_W`, 16, instruction word width; opcode = `[DATA_W-1 -: 4]`, operand = `[ADDR_W-1:0]`; requires `DATA_W >= ADDR_W + 4`
- `RESET_PC`, 0, PC value after reset
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `imem_req`  out  1  fetch request to instruction memory
- `imem_addr`  out  ADDR_W  fetch address (= PC)
- `imem_ack`  in  1  memory returns `imem_data` valid this cycle
- `imem_data`  in  DATA_W  instruction word
- `opcode`  out  4  IR opcode field, to control unit
- `operand`  out  ADDR_W  IR address field, to datapath/control
- `instr_valid`  out  1  IR holds an instruction awaiting execution
- `exec_done`  in  1  downstream has finished the current instruction
- `pc_src`  in  1  control unit: load PC from operand (conditional branch taken)
- `jmp_uncond`  in  1  control unit: unconditional jump
- `pc`  out  ADDR_W  current PC

## Operation
- Two-state FSM: FETCH, EXEC. All outputs derive from registers/state (Moore); no combinational path input→output.
- FETCH: `imem_req`=1, `imem_addr`=PC, `instr_valid`=0. On `imem_ack`=1: IR <= `imem_data`; next state EXEC. Without ack: stay, request held, address stable.
- EXEC: `imem_req`=0, `instr_valid`=1, `opcode`/`operand` stable from IR. On `exec_done`=1: PC <= `operand` if (`pc_src` | `jmp_uncond`), else PC <= PC+1; next state FETCH. Without `exec_done`: stay, PC and IR unchanged.
- `pc_src`/`jmp_uncond` sampled only in the cycle `exec_done`=1 in EXEC. Both high = jump (same as either).
- PC+1 is modulo 2^ADDR_W: PC = all-ones increments to 0. Jump target is taken unmodified.
- `imem_ack` outside FETCH ignored (no IR write). `exec_done` outside EXEC ignored (no PC change).
- Opcode values carry no meaning here; every opcode follows the same FETCH/EXEC path, including 0000 and undefined encodings.
- No flush or stall inputs; backpressure is entirely via `imem_ack` and `exec_done`.

## Timing
- Reset (async assert, any state, including a pending fetch): state=FETCH, PC=`RESET_PC`, IR=0. Outputs while reset is asserted: `imem_req`=0, `instr_valid`=0, `opcode`=0, `operand`=0, `pc`=`RESET_PC`. `imem_req` forced low during reset. First cycle after deassertion: `imem_req`=1, `imem_addr`=`RESET_PC`.
- An ack arriving in the same cycle as reset assertion is lost; the fetch restarts from `RESET_PC`.
- Ack may come in the first request cycle (zero wait states). `instr_valid` rises on the next clock edge.
- Minimum 2 cycles per instruction: FETCH+ack edge → EXEC; EXEC+`exec_done` edge → FETCH at the new PC. Each memory wait cycle or `exec_done` delay cycle adds one.
- New PC is visible on `pc`/`imem_addr` in the cycle `imem_req` reasserts.

## Test plan
- Reset: assert `rst` mid-cycle with `RESET_PC`=0x010 → outputs take reset values immediately, asynchronously. After release: `imem_req`=1, `imem_addr`=0x010, `instr_valid`=0.
- Sequential: memory acks immediately with words 0x2005, 0x3006, and `exec_done` is driven the cycle `instr_valid` rises → `opcode` 2 then 3, `operand` 0x005 then 0x006, addresses 0x000, 0x001, 0x002 with one instruction every 2 cycles.
- Jump: IR=0x8ABC, `exec_done`=1 with `jmp_uncond`=1 → next `imem_addr`=0xABC. Repeat with only `pc_src`=1 → 0xABC. Repeat with neither → PC+1.
- Wait states: ack delayed 3 cycles and `exec_done` delayed 2 cycles → `imem_addr`, `opcode`, `operand`, `pc` stable throughout. Stray ack in EXEC and stray `exec_done` in FETCH cause no change.
- Wrap: PC=0xFFF, non-jump completion → next `imem_addr`=0x000.
- Reset mid-fetch: assert `rst` while `imem_req`=1 with no ack yet, then ack on release cycle 2 → IR loaded from the `RESET_PC` fetch only, and there is no stale `instr_valid`.
